riscv_memory_responder: RTL
===========================

// Module: riscv_memory_responder
// PURPOSE
//  Memory-side responder for the core memory bus: answers the single merged request stream from the cache arbiter.
//  Serves word RAM plus a small MMIO window (debug console FIFO, 64-bit cycle counter), one request per clock.
//  Fixed 1-cycle response latency, matching the arbiter's one-stage routing of memory_ready.
// PARAMETERS
//  RAM_WORD_BITS  14            log2 of RAM depth in 32-bit words; RAM occupies 0 .. 4*2^RAM_WORD_BITS-1
//  MMIO_BASE      32'hFFFF_0000 base of 16-byte MMIO window
//  FIFO_DEPTH     8             console FIFO entries (power of 2, >=2)
//  INIT_FILE      ""            $readmemh image for RAM; empty = no init
// PORTS
//  clock                     in   1   single clock, rising edge
//  reset                     in   1   asynchronous, active-low
//  memory_address            in   32  request address (bits [1:0] ignored)
//  memory_read               in   1   read request this cycle
//  memory_write              in   1   write request this cycle
//  memory_out                in   32  write data from bus
//  memory_in                 out  32  read data to bus
//  memory_ready              out  1   response valid (one cycle after request)
//  memory_address_requested  out  32  word-aligned address the response belongs to
//  console_data              out  8   console byte
//  console_valid             out  1   console byte available
//  console_ready             in   1   sink accepts byte
//  fault                     out  1   sticky: access outside RAM and MMIO
// BEHAVIOUR
//  Reset (reset==0, async): memory_ready=0, memory_in=0, memory_address_requested=0, console_valid=0,
//   FIFO empty, overflow=0, fault=0, counter=0. RAM contents untouched. In-flight response dropped.
//  Request accepted every cycle read|write==1; no backpressure. Cycle N request -> cycle N+1 memory_ready=1,
//   memory_address_requested={addr[31:2],2'b00}, memory_in=data. Idle cycle -> memory_ready=0, memory_in holds.
//  Writes also get memory_ready at N+1; memory_in = word value before the write (read-before-write).
//  read&write both high: treated as write (as above).
//  RAM: index addr[RAM_WORD_BITS+1:2]; in range iff addr < 4*2^RAM_WORD_BITS. Back-to-back write N, read N+1 same
//   word -> read returns new value.
//  MMIO (addr[31:4]==MMIO_BASE[31:4]), offsets:
//   0x0 CONSOLE  W: push memory_out[7:0]; full FIFO -> byte dropped, overflow<=1. R: 0.
//   0x4 STATUS   R: {16'b0, count[7:0], 5'b0, overflow, empty, full}. W: bit2=1 clears overflow.
//   0x8 CNT_LO   R: counter[31:0]; also latches counter[63:32] into hi_shadow in the same cycle.
//   0xC CNT_HI   R: hi_shadow. Writes to 0x8/0xC ignored.
//  Counter: 64-bit, +1 every clock, wraps to 0.
//  Unmapped address: read returns 0, write ignored, still gets memory_ready; fault<=1 (cleared by reset only).
//  Console FIFO: byte popped when console_valid&console_ready; console_data stable while valid&!ready.
//   Push and pop in same cycle on full FIFO: both succeed, no overflow. On empty: pushed byte appears
//   on console_valid next cycle (no bypass).
//  count width = clog2(FIFO_DEPTH)+1, zero-extended into STATUS[15:8].
// STRUCTURE
//  Shared header riscv_memory_map.vh: MMIO offsets (CONSOLE/STATUS/CNT_LO/CNT_HI), STATUS bit indices,
//   default MMIO_BASE.
//  Sub-module riscv_console_fifo (sync FIFO, push/pop, full/empty/count); RAM inferred inline as
//   single-port sync-read array.
// TESTING
//  1 Write 0x1234_5678 @0x40 cycle N, read @0x40 N+1 -> ready at N+1 (memory_in=old) and N+2 (memory_in=0x12345678),
//    addr_requested=0x40 both.
//  2 Read @0x43 -> memory_address_requested=0x40, ready exactly one cycle later; idle cycle -> ready=0.
//  3 9 pushes to CONSOLE with console_ready=0 (DEPTH 8) -> STATUS=0x0000_0805; write 0x4 STATUS with bit2=1 ->
//    overflow clears; drain yields first 8 bytes in order.
//  4 FIFO full, push with console_ready=1 same cycle -> count stays 8, overflow stays 0.
//  5 Force counter to 0x0000_0000_FFFF_FFFF, read CNT_LO then CNT_HI -> HI=1, value coherent with LO latch.
//  6 Read 0x8000_0000 -> memory_in=0, ready=1, fault=1; assert reset mid-request -> no ready next cycle, fault=0.

Source files
------------

// File: rtl/riscv_memory_responder_pkg.sv
// Shared memory map for the memory responder: MMIO register offsets,
// STATUS bit positions, default MMIO base and the address decoder.
package riscv_memory_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

  // Offsets inside the 16-byte MMIO window
  localparam logic [3:0] MMIO_CONSOLE = 4'h0;
  localparam logic [3:0] MMIO_STATUS  = 4'h4;
  localparam logic [3:0] MMIO_CNT_LO  = 4'h8;
  localparam logic [3:0] MMIO_CNT_HI  = 4'hC;

  // STATUS register bit positions (count lives in [15:8])
  localparam int STATUS_FULL_BIT     = 0;
  localparam int STATUS_EMPTY_BIT    = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_NONE
  } region_e;

  // RAM takes priority; anything that is neither RAM nor MMIO is unmapped
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input int unsigned ram_word_bits,
                                            input logic [31:0] mmio_base);
    if ((addr >> (ram_word_bits + 2)) == 32'd0) return REGION_RAM;
    if (addr[31:4] == mmio_base[31:4]) return REGION_MMIO;
    return REGION_NONE;
  endfunction

endpackage

// File: rtl/riscv_console_fifo.sv
// Synchronous FIFO for the debug console. Push while full is accepted only
// when a pop happens in the same cycle; a byte pushed into an empty FIFO
// shows up on the output one cycle later (no bypass path).
module riscv_console_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              pop_fire, push_fire;

  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (count_o == (AW+1)'(DEPTH));
  assign pop_fire   = pop_i & ~empty_o;
  assign push_fire  = push_i & (~full_o | pop_fire);
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Read/write pointers carry one extra wrap bit to tell full from empty
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_fire)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is data only, so it is left out of reset
  always_ff @(posedge clk_i) begin
    if (push_fire) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/riscv_memory_responder.sv
// Memory-side responder for the merged core memory bus. Every request is
// answered exactly one cycle later from word RAM or the MMIO window
// (console FIFO, STATUS, 64-bit cycle counter). Unmapped accesses still
// complete but latch a sticky fault.
module riscv_memory_responder
  import riscv_memory_responder_pkg::*;
#(
  parameter int          RAM_WORD_BITS = 14,
  parameter logic [31:0] MMIO_BASE     = MMIO_BASE_DEFAULT,
  parameter int          FIFO_DEPTH    = 8,
  parameter string       INIT_FILE     = "",
  // Counter value after reset; 0 in normal use
  parameter logic [63:0] CNT_INIT      = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] memory_address,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [31:0] memory_out,
  output logic [31:0] memory_in,
  output logic        memory_ready,
  output logic [31:0] memory_address_requested,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready,
  output logic        fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] ram_q [2**RAM_WORD_BITS];
  logic [31:0] ram_rd_q, mmio_rd_q, addr_q;
  logic        ready_q, src_ram_q, overflow_q, fault_q;
  logic [63:0] cnt_q;
  logic [31:0] hi_q;

  logic                     req, ram_sel, mmio_sel;
  logic [31:0]              addr_w, mmio_rdata;
  logic [3:0]               offset;
  logic [RAM_WORD_BITS-1:0] ram_idx;
  region_e                  region;
  logic                     fifo_full, fifo_empty, fifo_push, pop_fire, overflow_d, lo_latch;
  logic [CW-1:0]            fifo_count;
  logic                     unused_addr_lsbs;

  assign unused_addr_lsbs = ^memory_address[1:0];

  assign req      = memory_read | memory_write;
  assign addr_w   = {memory_address[31:2], 2'b00};
  assign offset   = addr_w[3:0];
  assign ram_idx  = memory_address[RAM_WORD_BITS+1:2];
  assign region   = decode_region(addr_w, RAM_WORD_BITS, MMIO_BASE);
  assign ram_sel  = req & (region == REGION_RAM);
  assign mmio_sel = req & (region == REGION_MMIO);

  // read&write together behaves as a write, so only a pure read latches HI
  assign lo_latch  = mmio_sel & ~memory_write & (offset == MMIO_CNT_LO);
  assign fifo_push = mmio_sel & memory_write & (offset == MMIO_CONSOLE);
  assign pop_fire  = console_ready & ~fifo_empty;

  // Overflow: set by a dropped push, cleared by writing STATUS with bit2 set
  always_comb begin
    overflow_d = overflow_q;
    if (fifo_push & fifo_full & ~pop_fire) overflow_d = 1'b1;
    if (mmio_sel & memory_write & (offset == MMIO_STATUS) & memory_out[STATUS_OVERFLOW_BIT])
      overflow_d = 1'b0;
  end

  // MMIO read mux, sampled from pre-edge register state
  always_comb begin
    mmio_rdata = '0;
    if (region == REGION_MMIO) begin
      case (offset)
        MMIO_STATUS: begin
          mmio_rdata[15:8]                = 8'(fifo_count);
          mmio_rdata[STATUS_OVERFLOW_BIT] = overflow_q;
          mmio_rdata[STATUS_EMPTY_BIT]    = fifo_empty;
          mmio_rdata[STATUS_FULL_BIT]     = fifo_full;
        end
        MMIO_CNT_LO: mmio_rdata = cnt_q[31:0];
        MMIO_CNT_HI: mmio_rdata = hi_q;
        default:     mmio_rdata = '0;
      endcase
    end
  end

  // Single-port synchronous RAM with read-before-write on the same word
  always_ff @(posedge clock) begin
    if (ram_sel) begin
      ram_rd_q <= ram_q[ram_idx];
      if (memory_write) ram_q[ram_idx] <= memory_out;
    end
  end

  // Response, counter, shadow and sticky status registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q    <= 1'b0;
      addr_q     <= '0;
      src_ram_q  <= 1'b0;
      mmio_rd_q  <= '0;
      overflow_q <= 1'b0;
      fault_q    <= 1'b0;
      cnt_q      <= CNT_INIT;
      hi_q       <= '0;
    end else begin
      ready_q    <= req;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_q + 64'd1;
      if (req) begin
        addr_q    <= addr_w;
        src_ram_q <= (region == REGION_RAM);
        if (region != REGION_RAM) mmio_rd_q <= mmio_rdata;
      end
      if (lo_latch) hi_q <= cnt_q[63:32];
      if (req & (region == REGION_NONE)) fault_q <= 1'b1;
    end
  end

  riscv_console_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_console_fifo (
    .clk_i       (clock),
    .rst_ni      (reset),
    .push_i      (fifo_push),
    .push_data_i (memory_out[7:0]),
    .pop_i       (console_ready),
    .pop_data_o  (console_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Both data sources only update on their own requests, so idle cycles hold
  assign memory_in                = src_ram_q ? ram_rd_q : mmio_rd_q;
  assign memory_ready             = ready_q;
  assign memory_address_requested = addr_q;
  assign console_valid            = ~fifo_empty;
  assign fault                    = fault_q;

endmodule
